// File: rtl/led_code_if.sv
// Status LED arbiter bundle: requester side and LED side.
// The arbiter takes the slave view, the status sources the master view.
interface led_code_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]   req;
   logic [4*N_REQ-1:0] code;
   logic               led;
   logic [N_REQ-1:0]   grant;
   logic               busy;
   logic               done;

   modport master (
      output req, code,
      input  led, grant, busy, done
   );

   modport slave (
      input  req, code,
      output led, grant, busy, done
   );
endinterface

// File: rtl/led_code_arbiter.sv
// Round-robin sharing of one status LED; each owner shows a k-pulse burst
// followed by a dark gap before the LED is handed on.
module led_code_arbiter #(
   parameter int FREQ_HZ   = 100000000,
   parameter int UNIT_NS   = 250000000,
   parameter int GAP_UNITS = 4,
   parameter int N_REQ     = 4
) (
   input logic       clk,
   input logic       reset,
   led_code_if.slave bus
);
   localparam int UNIT_CYC = UNIT_NS / (1000000000 / FREQ_HZ);
   localparam int RW       = $clog2(N_REQ);

   typedef enum logic [1:0] {
      IDLE,
      ON,
      OFF,
      GAP
   } state_t;

   state_t             state_q, state_d;
   logic [N_REQ-1:0]   req_q;
   logic [4*N_REQ-1:0] code_q;
   logic [3:0]         nib [N_REQ];
   logic [RW-1:0]      rr_q, rr_d;
   logic [31:0]        pre_q, pre_d;
   logic [3:0]         pulses_q, pulses_d;
   logic [31:0]        gap_q, gap_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic               led_q, led_d;
   logic               done_q, done_d;
   logic               tick;
   logic               found;
   logic [RW-1:0]      g_idx;

   for (genvar i = 0; i < N_REQ; i++) begin : g_nib
      assign nib[i] = code_q[4*i +: 4];
   end

   assign tick = (pre_q == 32'(UNIT_CYC - 1));

   // First eligible index at or after rr, wrapping.
   always_comb begin
      found = 1'b0;
      g_idx = '0;
      for (int j = 0; j < N_REQ; j++) begin
         logic [RW-1:0] idx;
         idx = RW'((int'(rr_q) + j) % N_REQ);
         if (!found && req_q[idx] && nib[idx] != 4'd0) begin
            found = 1'b1;
            g_idx = idx;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      pulses_d = pulses_q;
      gap_d    = gap_q;
      grant_d  = grant_q;
      pre_d    = tick ? 32'd0 : pre_q + 32'd1;
      unique case (state_q)
         IDLE: begin
            pre_d = 32'd0;
            if (found) begin
               state_d  = ON;
               grant_d  = N_REQ'(1) << g_idx;
               pulses_d = nib[g_idx];
               rr_d     = (int'(g_idx) == N_REQ - 1) ? '0 : g_idx + RW'(1);
            end
         end
         ON: begin
            if (tick) begin
               pulses_d = pulses_q - 4'd1;
               if (pulses_q == 4'd1) begin
                  state_d = GAP;
                  gap_d   = 32'(GAP_UNITS - 1);
               end else begin
                  state_d = OFF;
               end
            end
         end
         OFF: begin
            if (tick) state_d = ON;
         end
         GAP: begin
            if (tick) begin
               if (gap_q == 32'd0) begin
                  state_d = IDLE;
                  grant_d = '0;
                  pre_d   = 32'd0;
               end else begin
                  gap_d = gap_q - 32'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      led_d  = (state_d == ON);
      // Look one cycle ahead so the registered done lands on the last gap cycle.
      done_d = (state_d == GAP) && (gap_d == 32'd0)
               && (pre_d == 32'(UNIT_CYC - 1));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         req_q    <= '0;
         code_q   <= '0;
         rr_q     <= '0;
         pre_q    <= 32'd0;
         pulses_q <= 4'd0;
         gap_q    <= 32'd0;
         grant_q  <= '0;
         led_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         req_q    <= bus.req;
         code_q   <= bus.code;
         rr_q     <= rr_d;
         pre_q    <= pre_d;
         pulses_q <= pulses_d;
         gap_q    <= gap_d;
         grant_q  <= grant_d;
         led_q    <= led_d;
         done_q   <= done_d;
      end
   end

   assign bus.led   = led_q;
   assign bus.grant = grant_q;
   assign bus.done  = done_q;
   assign bus.busy  = (state_q != IDLE);
endmodule

// File: doc/led_code_arbiter.md
# led_code_arbiter

Shares the single board status LED among up to N_REQ requesters. Each requester signals a condition by showing a blink code: a repeated burst of k pulses followed by a dark gap. The block contains its own unit-time prescaler and a round-robin arbiter. A four-state sequencer owns the LED pin until a burst and its gap are complete, then hands the LED to the next requester. It sits between the status sources (link, error, activity flags) and the LED pin, and replaces direct free-running blink timers on that pin.

## Interface
- FREQ_HZ, 100000000, clk frequency in Hz.
- UNIT_NS, 250000000, length of one blink unit in ns. UNIT_CYC = UNIT_NS/(1000000000/FREQ_HZ), integer division, must be ≥1.
- GAP_UNITS, 4, length of the dark gap after a burst, in units. Must be ≥1.
- N_REQ, 4, number of requesters, 2..8.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  level request per requester; bit i asks to show code i.
- code  in  4*N_REQ  pulse count per requester; nibble i = code[4i+3:4i], valid 1..15; 0 = request ignored.
- led  out  1  LED drive, 1 = on.
- grant  out  N_REQ  one-hot owner of the LED; all zero when idle.
- busy  out  1  high while a sequence is in progress (any state except IDLE).
- done  out  1  one-cycle pulse on the final cycle of GAP.

## Operation
- Eligible requester: req[i]=1 and code nibble i ≠ 0.
- Round-robin pointer rr (clog2(N_REQ) bits):
  - In IDLE the search starts at index rr, wraps around, and selects the first eligible index g.
  - On grant, rr ← (g+1) mod N_REQ.
- Prescaler (32-bit): counts 0..UNIT_CYC-1 and asserts internal tick when it equals UNIT_CYC-1.
  - Cleared to 0 on grant.
  - Held at 0 in IDLE.
- On grant, the block latches g and its code into pulses_left (4 bits) and gap_cnt. Later changes to req or code do not affect the running sequence. There is no preemption, and dropping req mid-sequence does not shorten the sequence.
- States:
  - IDLE: led=0, grant=0, busy=0. On an eligible requester: grant ← onehot(g), pulses_left ← code_g, led ← 1, go to ON.
  - ON: led=1. On tick, pulses_left ← pulses_left-1.
    - If pulses_left was 1: led ← 0, gap_cnt ← GAP_UNITS-1, go to GAP.
    - Otherwise: led ← 0, go to OFF.
  - OFF: led=0. On tick: led ← 1, go to ON.
  - GAP: led=0. On tick:
    - If gap_cnt==0: done ← 1 for that cycle, grant ← 0, go to IDLE.
    - Otherwise: gap_cnt ← gap_cnt-1.
- led, grant and done are registered outputs. busy is decoded from the state register.
- Reset (asynchronous, active-low) sets state=IDLE, led=0, grant=0, done=0, rr=0, prescaler=0 and pulses_left=0. Reset asserted mid-sequence drops the LED immediately. There is no resume.

## Timing
- Grant latency: req seen eligible at edge n produces grant, busy and led=1 valid after edge n+1.
- A code of k gives (2k-1)·UNIT_CYC cycles of burst, then GAP_UNITS·UNIT_CYC cycles of gap.
- done is high during the last gap cycle. grant clears and IDLE is entered on the next edge.
- Earliest re-grant is one cycle after leaving GAP, so there is at least one IDLE cycle between owners.
- If a requester is still requesting after its own sequence, it is re-granted only when no other eligible requester sits between rr and it in round-robin order.

## Test plan
- Reset: reset low with random req/code → led=0, grant=0, busy=0, done=0. Same outputs hold while reset is low.
- Single code: UNIT_NS=100 (UNIT_CYC=10), GAP_UNITS=4, req=0001, code0=3.
  - Required: led high 10 / low 10 / high 10 / low 10 / high 10, then low 40.
  - done pulses 89 cycles after grant rises. grant=0001 throughout.
- Round robin: req=1111, all codes 1.
  - Required: grant order 0001 → 0010 → 0100 → 1000 → 0001.
  - Each owner holds for 50 cycles.
- Ineligible: req=0010 with code1=0 → busy stays 0 for 200 cycles. Setting code1=2 → grant=0010 on the next-but-one edge.
- Drop and change mid-sequence: code0=5. Deassert req0 and set code0=1 during the second ON. Required: still 5 pulses, then gap, then done.
- Reset mid-sequence: pull reset low during ON.
  - Required: led, grant and busy go to 0 before the next clk edge.
  - After release with req=1001, grant=0001 (rr reset to 0).
